icache: RTL

//  Direct-mapped, read-only instruction cache between the pipelined datapath fetch stage and the memory controller.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/icache.sv | 75 +++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared cache types: address split, frame layout and fetch FSM states.
package cpu_types_pkg;

  localparam int NSETS  = 16;
  localparam int IIDX_W = $clog2(NSETS);
  localparam int ITAG_W = 32 - IIDX_W - 2;

  // Fetch address viewed as {tag, idx, byte offset}
  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  // One-word cache frame
  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    logic [31:0]       data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only, one-word-per-frame instruction cache.
// Hits return combinationally; a miss fetches a single word from memory,
// fills the frame and returns to IDLE so the retried fetch hits.
//
// state | meaning
// IDLE  | serving hits; a miss latches the address and moves to FETCH
// FETCH | iREN held for miss_addr until iwait drops or the datapath yields
module icache
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  icache_frame_t frames [NSETS];
  icache_state_t state;
  icachef_t      miss_addr;
  icachef_t      req;
  icache_frame_t sel;
  logic          hit;
  logic          fill;

  // Address decode and hit detection; no hit is reported while a fill is outstanding
  always_comb begin
    req      = icachef_t'(imemaddr);
    sel      = frames[req.idx];
    hit      = imemREN & sel.valid & (sel.tag == req.tag);
    ihit     = hit & (state == IDLE);
    imemload = sel.data;
    iREN     = (state == FETCH) & imemREN;
    iaddr    = miss_addr;
    fill     = (state == FETCH) & imemREN & ~iwait;
  end

  // Fetch FSM; a dropped imemREN abandons the fill, an address change does not
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !hit) begin
            state     <= FETCH;
            miss_addr <= req;
          end
        end
        FETCH: begin
          if (!imemREN || !iwait)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame array; only a completed fill writes, overwriting any previous occupant
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NSETS; i++)
        frames[i] <= '0;
    end else if (fill) begin
      frames[miss_addr.idx] <= '{valid: 1'b1, tag: miss_addr.tag, data: iload};
    end
  end

endmodule
